// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle for fpu_issue_ctrl.
// rsp_timeout exists only when FPU_DIV_TIMEOUT_EN is defined.
interface fpu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [15:0]      req_opA;
    logic [15:0]      req_opB;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic [2:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
`ifdef FPU_DIV_TIMEOUT_EN
    logic             rsp_timeout;
`endif

    modport slave (
        input  req_valid, req_opA, req_opB, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
`ifdef FPU_DIV_TIMEOUT_EN
        , output rsp_timeout
`endif
    );

    modport master (
        output req_valid, req_opA, req_opB, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
`ifdef FPU_DIV_TIMEOUT_EN
        , input rsp_timeout
`endif
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Request FIFO and single-op issue sequencer in front of the fp16 fpu.
// Optional divide watchdog: define FPU_DIV_TIMEOUT_EN.
module fpu_issue_ctrl #(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int FIXED_LAT   = 1,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    fpu_issue_ctrl_if.slave req_rsp,
    output logic [15:0] fpu_opA,
    output logic [15:0] fpu_opB,
    output logic [1:0]  fpu_op,
    output logic        fpu_start,
    input  logic [15:0] fpu_result,
    input  logic        fpu_overflow,
    input  logic        fpu_underflow,
    input  logic        fpu_inexact,
    input  logic        fpu_valid,
    input  logic        fpu_busy,
    output logic        idle
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENT_W   = 34 + TAG_W;
    localparam int CNT_MAX = (DIV_TIMEOUT > FIXED_LAT) ? DIV_TIMEOUT : FIXED_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] head;
    logic [1:0]       head_op;

    state_t           state_reg;
    logic [1:0]       op_reg;
    logic [15:0]      opa_reg;
    logic [15:0]      opb_reg;
    logic [TAG_W-1:0] tag_reg;
    logic             start_reg;
    logic [CW-1:0]    wait_cnt_reg;
    logic             rsp_valid_reg;
    logic [15:0]      rsp_result_reg;
    logic [2:0]       rsp_flags_reg;
    logic [TAG_W-1:0] rsp_tag_reg;
`ifdef FPU_DIV_TIMEOUT_EN
    logic             rsp_timeout_reg;
`endif

    // Extra pointer MSB tells full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign push       = req_rsp.req_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign head_op    = head[33:32];
    // A divide at the head waits in IDLE while the divider is still occupied.
    assign pop        = (state_reg == ST_IDLE) && !fifo_empty &&
                        !((head_op == OP_DIV) && fpu_busy);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= {req_rsp.req_tag, req_rsp.req_op,
                                             req_rsp.req_opB, req_rsp.req_opA};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            op_reg         <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            tag_reg        <= '0;
            start_reg      <= 1'b0;
            wait_cnt_reg   <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= '0;
            rsp_tag_reg    <= '0;
`ifdef FPU_DIV_TIMEOUT_EN
            rsp_timeout_reg <= 1'b0;
`endif
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        opa_reg   <= head[15:0];
                        opb_reg   <= head[31:16];
                        op_reg    <= head_op;
                        tag_reg   <= head[34 +: TAG_W];
                        start_reg <= (head_op == OP_DIV);
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (op_reg == OP_DIV) begin
                        if (fpu_valid) begin
                            rsp_result_reg <= fpu_result;
                            rsp_flags_reg  <= {fpu_overflow, fpu_underflow, fpu_inexact};
                            rsp_tag_reg    <= tag_reg;
                            rsp_valid_reg  <= 1'b1;
                            state_reg      <= ST_RESP;
`ifdef FPU_DIV_TIMEOUT_EN
                            rsp_timeout_reg <= 1'b0;
                        end else if (wait_cnt_reg == CW'(DIV_TIMEOUT - 1)) begin
                            rsp_result_reg  <= 16'h7E00;
                            rsp_flags_reg   <= 3'b000;
                            rsp_tag_reg     <= tag_reg;
                            rsp_valid_reg   <= 1'b1;
                            rsp_timeout_reg <= 1'b1;
                            state_reg       <= ST_RESP;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
`endif
                        end
                    end else if (wait_cnt_reg == CW'(FIXED_LAT - 1)) begin
                        rsp_result_reg <= fpu_result;
                        rsp_flags_reg  <= {fpu_overflow, fpu_underflow, fpu_inexact};
                        rsp_tag_reg    <= tag_reg;
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= ST_RESP;
`ifdef FPU_DIV_TIMEOUT_EN
                        rsp_timeout_reg <= 1'b0;
`endif
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (req_rsp.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Operands stay on the latched registers from ISSUE through the capture cycle.
    assign fpu_opA   = opa_reg;
    assign fpu_opB   = opb_reg;
    assign fpu_op    = op_reg;
    assign fpu_start = start_reg;

    assign req_rsp.req_ready  = !fifo_full;
    assign req_rsp.rsp_valid  = rsp_valid_reg;
    assign req_rsp.rsp_result = rsp_result_reg;
    assign req_rsp.rsp_flags  = rsp_flags_reg;
    assign req_rsp.rsp_tag    = rsp_tag_reg;
`ifdef FPU_DIV_TIMEOUT_EN
    assign req_rsp.rsp_timeout = rsp_timeout_reg;
`endif

    assign idle = fifo_empty && (state_reg == ST_IDLE) && !rsp_valid_reg;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with a small behavioural fpu model.
// Timeout checks are built only when FPU_DIV_TIMEOUT_EN is defined.
module tb_fpu_issue_ctrl;
    localparam int DEPTH       = 4;
    localparam int TAG_W       = 4;
    localparam int FIXED_LAT   = 1;
    localparam int DIV_TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    logic [15:0] fpu_opA, fpu_opB, fpu_result;
    logic [1:0]  fpu_op;
    logic        fpu_start, fpu_overflow, fpu_underflow, fpu_inexact;
    logic        fpu_valid, fpu_busy, idle;

    fpu_issue_ctrl #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .FIXED_LAT(FIXED_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .req_rsp(bus),
        .fpu_opA(fpu_opA), .fpu_opB(fpu_opB), .fpu_op(fpu_op), .fpu_start(fpu_start),
        .fpu_result(fpu_result), .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .fpu_inexact(fpu_inexact), .fpu_valid(fpu_valid), .fpu_busy(fpu_busy), .idle(idle)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // fpu model: fixed ops valid one cycle after issue, divide after div_lat cycles
    function automatic logic [18:0] fpu_ref(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case ({op, a, b})
            {2'b00, 16'h3C00, 16'h4000}: return {3'b000, 16'h4200};
            {2'b00, 16'h3C00, 16'h3C00}: return {3'b000, 16'h4000};
            {2'b01, 16'h4000, 16'h3C00}: return {3'b000, 16'h3C00};
            {2'b10, 16'h4000, 16'h4200}: return {3'b000, 16'h4600};
            {2'b10, 16'h4000, 16'h4000}: return {3'b000, 16'h4400};
            {2'b10, 16'h7BFF, 16'h7BFF}: return {3'b101, 16'h7C00};
            {2'b11, 16'h3C00, 16'h4000}: return {3'b000, 16'h3800};
            {2'b11, 16'h3C00, 16'h4200}: return {3'b001, 16'h3555};
            default:                     return {3'b111, 16'hBAD0};
        endcase
    endfunction

    logic [15:0] fix_res, div_res;
    logic [2:0]  fix_flags, div_flags;
    logic        mdl_valid, mdl_busy;
    logic        force_busy = 1'b0;
    logic        div_hang = 1'b0;
    int          div_lat = 3;
    int          div_cnt;

    always @(posedge clk) begin
        if (!reset) begin
            mdl_valid <= 1'b0;
            mdl_busy  <= 1'b0;
            div_cnt   <= 0;
            fix_res   <= '0;
            fix_flags <= '0;
            div_res   <= '0;
            div_flags <= '0;
        end else begin
            {fix_flags, fix_res} <= fpu_ref(fpu_op, fpu_opA, fpu_opB);
            mdl_valid <= 1'b0;
            if (fpu_start) begin
                {div_flags, div_res} <= fpu_ref(fpu_op, fpu_opA, fpu_opB);
                mdl_busy <= 1'b1;
                div_cnt  <= div_lat;
            end else if (div_cnt > 0 && !div_hang) begin
                div_cnt <= div_cnt - 1;
                if (div_cnt == 1) begin
                    mdl_valid <= 1'b1;
                    mdl_busy  <= 1'b0;
                end
            end
        end
    end

    assign fpu_result    = mdl_valid ? div_res : fix_res;
    assign {fpu_overflow, fpu_underflow, fpu_inexact} = mdl_valid ? div_flags : fix_flags;
    assign fpu_valid     = mdl_valid;
    assign fpu_busy      = mdl_busy | force_busy;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0]      res;
        logic [2:0]       flags;
        logic [TAG_W-1:0] tag;
        logic [1:0]       op;
        logic             tmo;
    } exp_t;
    exp_t sb[$];

    initial forever begin
        @(negedge clk);
        #1;
        if (fpu_start) start_cnt++;
    end

    // Monitor: checks hold while stalled, op stable at capture, and response contents.
    logic        prev_stall = 1'b0;
    logic        prev_valid = 1'b0;
    logic [1:0]  last_op = 2'b00;
    logic [34:0] held;
    initial forever begin
        @(negedge clk);
        #1;
        if (reset) begin
            if (prev_stall && bus.rsp_valid)
                chk("rsp_hold", 32'({bus.rsp_result, bus.rsp_flags, bus.rsp_tag}), 32'(held));
            if (bus.rsp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got tag %0h expected none", bus.rsp_tag);
                end else begin
                    chk("capture_op", 32'(last_op), 32'(sb[0].op));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
                chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
                chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
`ifdef FPU_DIV_TIMEOUT_EN
                chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
`endif
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            held = {bus.rsp_result, bus.rsp_flags, bus.rsp_tag};
        end else begin
            prev_stall = 1'b0;
        end
        prev_valid = bus.rsp_valid;
        last_op    = fpu_op;
    end

    task automatic push_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [TAG_W-1:0] tag, input logic [15:0] er,
                            input logic [2:0] ef, input logic tmo);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_opA   = a;
        bus.req_opB   = b;
        bus.req_tag   = tag;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("push_accept", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            e.res = er; e.flags = ef; e.tag = tag; e.op = op; e.tmo = tmo;
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!idle && n < limit);
        chk("wait_idle", 32'(idle), 32'd1);
    endtask

    task automatic wait_rise(output int c);
        int   n = 0;
        logic prev;
        prev = bus.rsp_valid;
        c = -1;
        while (n < 500) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid && !prev) begin
                c = cyc;
                break;
            end
            prev = bus.rsp_valid;
        end
        if (c < 0) chk("rsp_arrival", 32'(bus.rsp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, s0, n;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_opA   = '0;
        bus.req_opB   = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_idle", 32'(idle), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_fpu_start", 32'(fpu_start), 32'd0);
        chk("reset_fpu_ops", 32'({fpu_op, fpu_opA}), 32'd0);
        chk("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
        reset = 1'b1;

        // add: latency from push to rsp_valid
        push_req(2'b00, 16'h3C00, 16'h4000, 4'd1, 16'h4200, 3'b000, 1'b0);
        c0 = cyc;
        wait_rise(c1);
        chk("add_latency", 32'(c1 - c0), 32'(FIXED_LAT + 2));
        wait_idle(50);

        // sub then mul back to back, spacing at full throughput
        push_req(2'b01, 16'h4000, 16'h3C00, 4'd2, 16'h3C00, 3'b000, 1'b0);
        push_req(2'b10, 16'h4000, 16'h4200, 4'd3, 16'h4600, 3'b000, 1'b0);
        wait_rise(c1);
        wait_rise(c2);
        chk("throughput", 32'(c2 - c1), 32'(FIXED_LAT + 3));
        wait_idle(50);

        // overflow flags pass through
        push_req(2'b10, 16'h7BFF, 16'h7BFF, 4'd4, 16'h7C00, 3'b101, 1'b0);
        wait_idle(50);

        // divide: one start pulse, response the cycle after fpu_valid
        s0 = start_cnt;
        push_req(2'b11, 16'h3C00, 16'h4000, 4'd5, 16'h3800, 3'b000, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fpu_valid && n < 100);
        @(negedge clk);
        chk("div_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("div_rsp_result", 32'(bus.rsp_result), 32'h3800);
        wait_idle(50);
        chk("div_start_pulses", 32'(start_cnt - s0), 32'd1);

        // divide held in IDLE while the divider reports busy
        force_busy = 1'b1;
        s0 = start_cnt;
        push_req(2'b11, 16'h3C00, 16'h4200, 4'd6, 16'h3555, 3'b001, 1'b0);
        repeat (6) @(negedge clk);
        chk("busy_no_start", 32'(start_cnt - s0), 32'd0);
        chk("busy_not_idle", 32'(idle), 32'd0);
        chk("busy_no_rsp", 32'(bus.rsp_valid), 32'd0);
        force_busy = 1'b0;
        wait_idle(50);
        chk("busy_start_after", 32'(start_cnt - s0), 32'd1);

        // backpressure: DEPTH+1 requests with the consumer stalled
        bus.rsp_ready = 1'b0;
        push_req(2'b00, 16'h3C00, 16'h4000, 4'd8,  16'h4200, 3'b000, 1'b0);
        push_req(2'b00, 16'h3C00, 16'h3C00, 4'd9,  16'h4000, 3'b000, 1'b0);
        push_req(2'b01, 16'h4000, 16'h3C00, 4'd10, 16'h3C00, 3'b000, 1'b0);
        push_req(2'b10, 16'h4000, 16'h4000, 4'd11, 16'h4400, 3'b000, 1'b0);
        push_req(2'b10, 16'h4000, 16'h4200, 4'd12, 16'h4600, 3'b000, 1'b0);
        @(negedge clk);
        chk("full_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (5) @(negedge clk);
        chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("stall_rsp_tag", 32'(bus.rsp_tag), 32'd8);
        bus.rsp_ready = 1'b1;
        wait_idle(100);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // reset while a divide is in WAIT, with requests queued behind it
        div_lat = 20;
        push_req(2'b11, 16'h3C00, 16'h4000, 4'd13, 16'h3800, 3'b000, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fpu_start && n < 50);
        repeat (2) @(negedge clk);
        push_req(2'b00, 16'h3C00, 16'h4000, 4'd14, 16'h4200, 3'b000, 1'b0);
        push_req(2'b00, 16'h3C00, 16'h3C00, 4'd15, 16'h4000, 3'b000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_fpu_start", 32'(fpu_start), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b1;
        div_lat = 3;
        repeat (30) @(negedge clk);
        chk("post_rst_idle", 32'(idle), 32'd1);

        // recovery after reset
        push_req(2'b00, 16'h3C00, 16'h4000, 4'd7, 16'h4200, 3'b000, 1'b0);
        wait_idle(50);

`ifdef FPU_DIV_TIMEOUT_EN
        // divide that never completes returns qNaN with the timeout marker
        div_hang = 1'b1;
        push_req(2'b11, 16'h3C00, 16'h4000, 4'd3, 16'h7E00, 3'b000, 1'b1);
        c0 = cyc;
        wait_rise(c1);
        chk("timeout_latency", 32'(c1 - c0), 32'(DIV_TIMEOUT + 2));
        wait_idle(50);
        div_hang = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
